// File: rtl/input_conditioner.sv
// input_conditioner: per-channel flop synchronizer, optional stability filter
// and rise/fall edge detector for asynchronous pins.
// Optional feature macro: INPUT_CONDITIONER_FILTER_EN (stability filter).
// With the macro undefined, data_out is the last synchronizer stage itself,
// so a change sampled by the first stage at edge k shows on data_out after
// edge k+STAGES-1; the filter register adds FILTER_CYCLES cycles on top.
module input_conditioner #(
  parameter int               STAGES        = 2,
  parameter int               WIDTH         = 4,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject illegal configurations at elaboration time.
  if (STAGES < 2) begin : g_bad_stages
    $error("input_conditioner: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("input_conditioner: FILTER_CYCLES must be >= 1");
  end

  // Stage 0 is the metastability catcher; the last stage is the usable level.
  logic [STAGES-1:0][WIDTH-1:0] sync_p;
  logic [WIDTH-1:0]             sync;
  logic [WIDTH-1:0]             prev;

  assign sync = sync_p[STAGES-1];

  // Synchronizer shift chain, all channels in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= {STAGES{RESET_VALUE}};
    end else begin
      sync_p <= {sync_p[STAGES-2:0], data_in};
    end
  end

`ifdef INPUT_CONDITIONER_FILTER_EN
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] level;

  // Stability filter: a new level must persist FILTER_CYCLES cycles; any
  // return to the accepted level throws away the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level[i] <= sync[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign data_out = level;
`else
  assign data_out = sync;
`endif

  // Edge history: last cycle's data_out; equal to data_out after reset so
  // no pulse follows reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= RESET_VALUE;
    end else begin
      prev <= data_out;
    end
  end

  assign rise = data_out & ~prev;
  assign fall = ~data_out & prev;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a cycle-level reference model pushes the
// expected {data_out, rise, fall} into a scoreboard queue on every driven
// edge; the entry is popped and compared just after that edge. Directed
// checks cover reset, latency, glitch handling and reset during activity.
// Builds with or without INPUT_CONDITIONER_FILTER_EN.
module tb_input_conditioner;

  localparam int         W   = 4;
  localparam int         STG = 2;
  localparam int         FC  = 4;
  localparam logic [3:0] RV  = 4'b0101;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int checks = 0;
  int passed = 0;

  input_conditioner #(
    .STAGES(STG), .WIDTH(W), .FILTER_CYCLES(FC), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .data_out(data_out), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [STG-1:0][W-1:0] m_chain;
  logic [W-1:0]          m_out;
  logic [W-1:0]          m_prev;
  int                    m_cnt [W];
  logic [3*W-1:0]        sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_chain = {STG{RV}};
    m_out   = RV;
    m_prev  = RV;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  task automatic model_edge(input logic [W-1:0] din);
    logic [W-1:0] sync_old;
    logic [W-1:0] out_old;
    sync_old = m_chain[STG-1];
    out_old  = m_out;
`ifdef INPUT_CONDITIONER_FILTER_EN
    for (int i = 0; i < W; i++) begin
      if (sync_old[i] == out_old[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == FC - 1) begin
        m_out[i] = sync_old[i];
        m_cnt[i] = 0;
      end else m_cnt[i] = m_cnt[i] + 1;
    end
`endif
    m_prev = out_old;
    for (int s = STG - 1; s > 0; s--) m_chain[s] = m_chain[s-1];
    m_chain[0] = din;
`ifndef INPUT_CONDITIONER_FILTER_EN
    m_out = m_chain[STG-1];
`endif
    sb.push_back({m_out, m_out & ~m_prev, ~m_out & m_prev});
  endtask

  // One clock with data_in held; compare DUT just after the edge.
  task automatic cyc(input logic [W-1:0] din);
    logic [3*W-1:0] e;
    data_in = din;
    @(posedge clk);
    model_edge(din);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_data_out", 32'(data_out), 32'(e[3*W-1:2*W]));
      check("sb_rise", 32'(rise), 32'(e[2*W-1:W]));
      check("sb_fall", 32'(fall), 32'(e[W-1:0]));
    end
  endtask

`ifdef INPUT_CONDITIONER_FILTER_EN
  localparam int  EXP_LAT  = STG + FC;
  localparam int  GLITCH3  = 0;
  localparam int  GLITCH1  = 0;
`else
  localparam int  EXP_LAT  = STG;
  localparam int  GLITCH3  = 1;
  localparam int  GLITCH1  = 1;
`endif

  initial begin
    int lat;
    int nrise;
    int nfall;
    logic seen;
    logic [W-1:0] v;

    // Reset held with opposite input pattern
    rst_n   = 1'b0;
    data_in = 4'b1010;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'(RV));
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_fall", 32'(fall), 32'd0);
    rst_n = 1'b1;
    cyc(4'b1010);
    check("post_rst_no_pulse", 32'(rise | fall), 32'd0);
    repeat (8) cyc(4'b1010);
    repeat (10) cyc(4'b0000);

    // Stable step on ch0: latency and single-cycle pulse
    lat = 0;
    nrise = 0;
    for (int n = 1; n <= 14; n++) begin
      cyc(4'b0001);
      if (rise[0]) begin
        nrise++;
        if (lat == 0) lat = n;
      end
    end
    check("step_latency", 32'(lat), 32'(EXP_LAT));
    check("step_rise_count", 32'(nrise), 32'd1);
    check("step_other_ch", 32'(data_out), 32'b0001);

    // ch1 glitch of 3 cycles
    nrise = 0;
    nfall = 0;
    repeat (3) begin
      cyc(4'b0011);
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
    end
    repeat (10) begin
      cyc(4'b0001);
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
    end
    check("glitch3_rise", 32'(nrise), 32'(GLITCH3));
    check("glitch3_fall", 32'(nfall), 32'(GLITCH3));

    // ch1 pulse of 4 cycles: accepted in both builds
    nrise = 0;
    nfall = 0;
    repeat (4) begin
      cyc(4'b0011);
      nrise += int'(rise[1]);
    end
    repeat (10) begin
      cyc(4'b0001);
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
    end
    check("pulse4_rise", 32'(nrise), 32'd1);
    check("pulse4_fall", 32'(nfall), 32'd1);

    // ch1 glitch of 1 cycle
    nrise = 0;
    nfall = 0;
    cyc(4'b0011);
    nrise += int'(rise[1]);
    repeat (10) begin
      cyc(4'b0001);
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
    end
    check("glitch1_rise", 32'(nrise), 32'(GLITCH1));
    check("glitch1_fall", 32'(nfall), 32'(GLITCH1));

    // All channels together
    repeat (10) cyc(4'b0000);
    seen = 1'b0;
    repeat (10) begin
      cyc(4'b1111);
      if (rise == 4'b1111) seen = 1'b1;
    end
    check("multi_rise_all", 32'(seen), 32'd1);
    seen = 1'b0;
    nrise = 0;
    repeat (10) begin
      cyc(4'b0110);
      if (fall == 4'b1001) seen = 1'b1;
      if (rise != 4'b0000) nrise++;
    end
    check("multi_fall_1001", 32'(seen), 32'd1);
    check("multi_no_rise", 32'(nrise), 32'd0);

    // Reset asserted mid-count / mid-pulse on ch2
    repeat (2) cyc(4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'(RV));
    check("midrst_rise", 32'(rise), 32'd0);
    check("midrst_fall", 32'(fall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0010);
    check("midrst_ch2_level", 32'(data_out[2]), 32'(RV[2]));
    repeat (12) cyc(4'b0010);

    // Random hold lengths, scoreboard only
    for (int k = 0; k < 40; k++) begin
      v = W'($urandom_range(0, 15));
      repeat ($urandom_range(1, 6)) cyc(v);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
